// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch request issue and in-order response queue feeding decode; optional IFQ_BYPASS_EN
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] PCF,
    input  logic            PCSrcE,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            StallF,
    output logic            valid_d,
    input  logic            ready_d,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] InstrD
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [AW-1:0]    wr_ptr, fill_ptr, rd_ptr;
    logic [CW-1:0]    count, drop_cnt, unfilled;

    logic [CW:0] occupancy;
    logic        accept, pop, head_filled;
    logic        rsp_drop, rsp_take, rsp_write, bypass_hit;

    // Slots still owed a response after a flush count against capacity.
    assign occupancy      = {1'b0, count} + {1'b0, drop_cnt};
    assign imem_req_valid = reset_n & ~PCSrcE & (occupancy < DEPTH_OCC);
    assign imem_req_addr  = PCF;
    assign accept         = imem_req_valid & imem_req_ready;
    assign StallF         = ~accept;

    assign head_filled = filled_q[rd_ptr];
    assign rsp_drop    = imem_rsp_valid & (drop_cnt != '0);
    assign rsp_take    = imem_rsp_valid & (drop_cnt == '0) & (unfilled != '0);

`ifdef IFQ_BYPASS_EN
    assign bypass_hit = (count == CW'(1)) & ~head_filled & (drop_cnt == '0) & imem_rsp_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign valid_d   = (head_filled | bypass_hit) & ~PCSrcE;
    assign pop       = valid_d & ready_d;
    // A bypassed response that is consumed the same cycle never lands in the queue.
    assign rsp_write = rsp_take & ~PCSrcE & ~(bypass_hit & pop);

    always_comb begin
        PCD    = '0;
        InstrD = '0;
        if (valid_d) begin
            PCD    = pc_q[rd_ptr];
            InstrD = bypass_hit ? imem_rsp_data : instr_q[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            pc_q[wr_ptr] <= PCF;
        if (rsp_write)
            instr_q[fill_ptr] <= imem_rsp_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            unfilled <= '0;
            drop_cnt <= '0;
            filled_q <= '0;
        end else if (PCSrcE) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            unfilled <= '0;
            filled_q <= '0;
            // Outstanding requests become drops; a response taken this cycle retires one of them.
            drop_cnt <= drop_cnt - CW'(rsp_drop) + unfilled - CW'(rsp_take);
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (rsp_write)
                filled_q[fill_ptr] <= 1'b1;
            if (rsp_take)
                fill_ptr <= fill_ptr + AW'(1);
            if (pop) begin
                filled_q[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + AW'(1);
            end
            count    <= count + CW'(accept) - CW'(pop);
            unfilled <= unfilled + CW'(accept) - CW'(rsp_take);
            drop_cnt <= drop_cnt - CW'(rsp_drop);
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed scoreboard bench for ifetch_queue with an in-order imem model
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        reset_n, PCSrcE, imem_req_ready, imem_rsp_valid, ready_d;
    logic [31:0] pcf, imem_rsp_data, target;
    logic        imem_req_valid, StallF, valid_d;
    logic [31:0] imem_req_addr, PCD, InstrD;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat = 1;
    int last_due = -1;

    logic [31:0] sb_pc[$];
    logic [31:0] fl_addr[$];
    int          fl_due[$];

    logic        s_req_valid, s_stallf, s_valid_d;
    logic [31:0] s_req_addr, s_pcd, s_instrd;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .PCF(pcf), .PCSrcE(PCSrcE),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .StallF(StallF), .valid_d(valid_d),
        .ready_d(ready_d), .PCD(PCD), .InstrD(InstrD)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score pops/accepts, then drive the next cycle after the edge.
    task automatic step();
        bit          acc, pp, fl;
        logic [31:0] exp_pc;
        int          due;
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_stallf    = StallF;
        s_valid_d   = valid_d;
        s_pcd       = PCD;
        s_instrd    = InstrD;
        acc = imem_req_valid && imem_req_ready;
        pp  = valid_d && ready_d;
        fl  = PCSrcE;
        if (pp) begin
            if (sb_pc.size() == 0) begin
                check("spurious_pop", valid_d, 1'b0);
            end else begin
                exp_pc = sb_pc.pop_front();
                check("pcd", PCD, exp_pc);
                check("instrd", InstrD, instr_of(exp_pc));
            end
        end
        if (acc) begin
            sb_pc.push_back(pcf);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            fl_addr.push_back(pcf);
            fl_due.push_back(due);
            last_due = due;
        end
        if (fl)
            sb_pc.delete();
        @(posedge clk);
        #1;
        cyc++;
        if (fl)
            pcf = target;
        else if (acc)
            pcf = pcf + 32'd4;
        if (fl_due.size() > 0 && fl_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(fl_addr.pop_front());
            void'(fl_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        reset_n        = 1'b0;
        PCSrcE         = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        sb_pc.delete();
        fl_addr.delete();
        fl_due.delete();
        last_due = -1;
        pcf = start_pc;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        imem_req_ready = 1'b0;
        ready_d        = 1'b1;
        for (int i = 0; i < 40 && (sb_pc.size() != 0 || fl_due.size() != 0); i++)
            step();
        check(tag, sb_pc.size(), 0);
    endtask

    initial begin
        reset_n = 1'b0; PCSrcE = 1'b0; imem_req_ready = 1'b1; ready_d = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; pcf = 32'h0; target = 32'h0;

        step();
        check("rst_req_valid", s_req_valid, 1'b0);
        check("rst_stallf", s_stallf, 1'b1);
        check("rst_valid_d", s_valid_d, 1'b0);
        check("rst_pcd", s_pcd, 32'h0);
        check("rst_instrd", s_instrd, 32'h0);

        // Straight line, 1-cycle imem
        imem_req_ready = 1'b1; ready_d = 1'b1; lat = 1;
        do_reset(32'h0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("t1_stallf", s_stallf, 1'b0);
            check("t1_valid_d", s_valid_d, k >= 2);
        end
        drain("t1_drain");

        // Fill to DEPTH with decode stalled
        imem_req_ready = 1'b1; ready_d = 1'b0; lat = 1;
        do_reset(32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t2_req_valid", s_req_valid, 1'b1);
            check("t2_stallf", s_stallf, 1'b0);
        end
        step();
        check("t2_full_req_valid", s_req_valid, 1'b0);
        check("t2_full_stallf", s_stallf, 1'b1);
        check("t2_full_valid_d", s_valid_d, 1'b1);
        ready_d = 1'b1;
        step();
        check("t2_pop_req_valid", s_req_valid, 1'b0);
        ready_d = 1'b0;
        step();
        check("t2_resume_valid", s_req_valid, 1'b1);
        check("t2_resume_addr", s_req_addr, 32'h10);
        drain("t2_drain");

        // Request backpressure
        imem_req_ready = 1'b1; ready_d = 1'b1; lat = 1;
        do_reset(32'h0);
        step();
        step();
        imem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_bp_stallf", s_stallf, 1'b1);
            check("t3_bp_addr", s_req_addr, 32'h8);
            check("t3_bp_req_valid", s_req_valid, 1'b1);
        end
        imem_req_ready = 1'b1;
        step();
        check("t3_go_stallf", s_stallf, 1'b0);
        check("t3_go_addr", s_req_addr, 32'h8);
        drain("t3_drain");

        // Flush with two requests in flight, 3-cycle imem
        imem_req_ready = 1'b1; ready_d = 1'b1; lat = 3;
        do_reset(32'h0);
        step();
        step();
        PCSrcE = 1'b1; target = 32'h100;
        step();
        check("t4_flush_req_valid", s_req_valid, 1'b0);
        check("t4_flush_valid_d", s_valid_d, 1'b0);
        PCSrcE = 1'b0;
        for (int k = 3; k < 7; k++) begin
            step();
            check("t4_wait_valid_d", s_valid_d, 1'b0);
        end
        step();
        check("t4_target_valid_d", s_valid_d, 1'b1);
        check("t4_target_pcd", s_pcd, 32'h100);
        drain("t4_drain");

        // Flush coincident with a response and a poppable head
        imem_req_ready = 1'b1; ready_d = 1'b1; lat = 1;
        do_reset(32'h0);
        step();
        step();
        PCSrcE = 1'b1; target = 32'h100;
        step();
        check("t5_flush_valid_d", s_valid_d, 1'b0);
        check("t5_flush_req_valid", s_req_valid, 1'b0);
        PCSrcE = 1'b0;
        step();
        check("t5_empty_valid_d", s_valid_d, 1'b0);
        step();
        check("t5_fill_valid_d", s_valid_d, 1'b0);
        step();
        check("t5_target_valid_d", s_valid_d, 1'b1);
        check("t5_target_pcd", s_pcd, 32'h100);
        drain("t5_drain");

        // Reset mid-stream with three entries allocated
        imem_req_ready = 1'b1; ready_d = 1'b0; lat = 1;
        do_reset(32'h0);
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("t6_rst_req_valid", imem_req_valid, 1'b0);
        check("t6_rst_stallf", StallF, 1'b1);
        check("t6_rst_valid_d", valid_d, 1'b0);
        check("t6_rst_pcd", PCD, 32'h0);
        check("t6_rst_instrd", InstrD, 32'h0);
        do_reset(32'h40);
        imem_req_ready = 1'b1; ready_d = 1'b1;
        step();
        check("t6_first_req_valid", s_req_valid, 1'b1);
        check("t6_first_addr", s_req_addr, 32'h40);
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
